// File: rtl/rr_mux_4to1.sv
// Four-into-one valid/ready merge with round-robin arbitration and a single
// registered output stage; each output beat carries its source channel index.
module rr_mux_4to1 #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [3:0]            in_valid_i,
    input  logic [4*DATA_W-1:0]   in_data_i,
    output logic [3:0]            in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [1:0]            out_sel_o,
    input  logic                  out_ready_i
);

    logic [DATA_W-1:0] ch_data [4];
    logic [1:0]        last_q;
    logic [3:0]        gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic              free;
    logic              take;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign ch_data[gi] = in_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Search starts one past the last winner and wraps 3 -> 0.
    always_comb begin
        logic [1:0] idx;
        gnt     = 4'b0;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        idx     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!gnt_any && in_valid_i[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    assign free       = !out_valid_o || out_ready_i;
    assign in_ready_o = (en_i && free && rst_ni) ? gnt : 4'b0;
    assign take       = |(in_valid_i & in_ready_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sel_o   <= 2'd0;
            last_q      <= 2'd3;
        end else if (take) begin
            out_valid_o <= 1'b1;
            out_data_o  <= ch_data[gnt_idx];
            out_sel_o   <= gnt_idx;
            last_q      <= gnt_idx;
        end else if (out_ready_i) begin
            // Drain only clears valid; payload and tag keep their last values.
            out_valid_o <= 1'b0;
        end
    end

endmodule
